pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of one payload channel.
REQ-002 Parameter NUM_CH, default 3, number of payload channels (e.g. V1, V2, E32); legal range 1..8.
REQ-003 Parameter PC_INC, default 4, constant added to in_pc4 to form out_pc8.
REQ-004 Parameter CNT_W, default 16, width of each statistics counter.
REQ-005 Parameter KEEP_PC_ON_FLUSH, default 0; 1 = flush keeps out_pc8 for exception attribution.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 stall  in  1  hold current contents this cycle.
REQ-009 flush  in  1  replace contents with a bubble this cycle.
REQ-010 in_valid  in  1  incoming instruction is real; 0 = upstream bubble.
REQ-011 in_data  in  NUM_CH*DATA_W  packed payload; channel k at bits [k*DATA_W +: DATA_W].
REQ-012 in_ir  in  32  instruction word.
REQ-013 in_pc4  in  32  PC+4 of the incoming instruction.
REQ-014 out_valid  out  1  registered valid.
REQ-015 out_data  out  NUM_CH*DATA_W  registered payload, same packing.
REQ-016 out_ir  out  32  registered instruction; 0 (nop) whenever out_valid=0.
REQ-017 out_pc8  out  32  registered in_pc4+PC_INC.
REQ-018 bubble_cnt  out  CNT_W  count of bubbles entered.
REQ-019 stall_cnt  out  CNT_W  count of stall cycles.

Function
REQ-020 Per-edge priority SHALL be: reset > flush > stall > load.
REQ-021 Load (no flush, no stall, in_valid=1): out_valid=1, out_data=in_data, out_ir=in_ir, out_pc8=in_pc4+PC_INC, one-cycle latency.
REQ-022 Addition for out_pc8 SHALL be modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000).
REQ-023 Load with in_valid=0: out_valid=0, out_data=0, out_ir=0, out_pc8=in_pc4+PC_INC; bubble_cnt increments.
REQ-024 Flush: out_valid=0, out_data=0, out_ir=0; out_pc8 cleared to 0 if KEEP_PC_ON_FLUSH=0, else unchanged; bubble_cnt increments.
REQ-025 Flush with stall simultaneously asserted: flush behaviour only; stall_cnt does not increment.
REQ-026 Stall (no flush): all out_* hold their previous values; stall_cnt increments; bubble_cnt unchanged.
REQ-027 Stall with out_valid=0 SHALL hold the bubble and not increment bubble_cnt.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 Payload channels SHALL be independent; no cross-channel bit movement for any NUM_CH.
REQ-030 Outputs SHALL depend only on registered state (no combinational path input->output).

Reset
REQ-031 Asserting reset SHALL immediately, without a clock edge, force out_valid=0, out_data=0, out_ir=0, out_pc8=0, bubble_cnt=0, stall_cnt=0.
REQ-032 While reset is high, stall, flush and in_* SHALL be ignored.
REQ-033 After reset deasserts, the first rising edge SHALL perform a normal priority evaluation per REQ-020.
REQ-034 Reset asserted mid-stall SHALL discard held contents; no state survives reset.

Verification
REQ-035 Load: in_valid=1, in_ir=0x8C220004, in_pc4=0x00003004, ch0=0x11 -> next edge out_valid=1, out_ir=0x8C220004, out_pc8=0x00003008, ch0=0x11.
REQ-036 Stall hold: load as REQ-035, then stall=1 for 3 cycles with new inputs -> outputs unchanged for 3 cycles, stall_cnt=3, bubble_cnt=0.
REQ-037 Flush+stall same cycle, KEEP_PC_ON_FLUSH=1, out_pc8=0x00003008 -> out_valid=0, out_ir=0, out_data=0, out_pc8=0x00003008, bubble_cnt+1, stall_cnt unchanged; repeat with KEEP_PC_ON_FLUSH=0 -> out_pc8=0.
REQ-038 Wrap: in_pc4=0xFFFFFFFC, PC_INC=4 -> out_pc8=0x00000000.
REQ-039 Saturation: CNT_W=4, stall held 20 cycles -> stall_cnt stops at 15.
REQ-040 Async reset: assert reset between edges while out_valid=1 -> all outputs 0 before next edge; deassert, load -> normal REQ-035 response.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush control and bubble/stall statistics.
// Carries valid, multi-channel payload, instruction word and PC+8 to the next stage.
module pipe_stage_reg #(
    parameter int DATA_W           = 32,
    parameter int NUM_CH           = 3,
    parameter int PC_INC           = 4,
    parameter int CNT_W            = 16,
    parameter bit KEEP_PC_ON_FLUSH = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [31:0]              in_ir,
    input  logic [31:0]              in_pc4,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [31:0]              out_ir,
    output logic [31:0]              out_pc8,
    output logic [CNT_W-1:0]         bubble_cnt,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam logic [31:0]      PC_STEP = 32'(PC_INC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A bubble enters on flush, or on a normal load of an upstream bubble.
    logic load;
    logic bubble_in;
    logic stall_in;

    assign load      = !flush && !stall;
    assign bubble_in = flush || (load && !in_valid);
    assign stall_in  = stall && !flush;

    // Control fields: valid, instruction word and PC+8.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ir    <= '0;
            out_pc8   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ir    <= '0;
            if (!KEEP_PC_ON_FLUSH) begin
                out_pc8 <= '0;
            end
        end else if (!stall) begin
            out_valid <= in_valid;
            out_ir    <= in_valid ? in_ir : 32'h0;
            out_pc8   <= in_pc4 + PC_STEP;
        end
    end

    // Each payload channel is its own register so no bits can cross channels.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] ch_q;

        // Channel k: cleared on reset/flush/bubble, held on stall.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ch_q <= '0;
            end else if (flush) begin
                ch_q <= '0;
            end else if (!stall) begin
                ch_q <= in_valid ? in_data[k*DATA_W +: DATA_W] : '0;
            end
        end

        assign out_data[k*DATA_W +: DATA_W] = ch_q;
    end

    // Saturating count of bubbles entering the stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (bubble_in && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    // Saturating count of stall cycles; a flush overrides the stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_in && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (pc cleared / pc kept on flush,
// 16-bit / 4-bit counters) checked against a behavioural model every cycle.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int NC = 3;
    localparam int W  = DW * NC;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          stall    = 1'b0;
    logic          flush    = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data  = '0;
    logic [31:0]   in_ir    = '0;
    logic [31:0]   in_pc4   = '0;

    logic          v0, v1;
    logic [W-1:0]  d0, d1;
    logic [31:0]   ir0, ir1, pc0, pc1;
    logic [15:0]   bc0, sc0;
    logic [3:0]    bc1, sc1;

    int n_vec = 0;
    int n_mis = 0;

    pipe_stage_reg #(
        .DATA_W(DW), .NUM_CH(NC), .PC_INC(4),
        .CNT_W(16), .KEEP_PC_ON_FLUSH(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ir(in_ir),
        .in_pc4(in_pc4), .out_valid(v0), .out_data(d0),
        .out_ir(ir0), .out_pc8(pc0), .bubble_cnt(bc0), .stall_cnt(sc0)
    );

    pipe_stage_reg #(
        .DATA_W(DW), .NUM_CH(NC), .PC_INC(4),
        .CNT_W(4), .KEEP_PC_ON_FLUSH(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ir(in_ir),
        .in_pc4(in_pc4), .out_valid(v1), .out_data(d1),
        .out_ir(ir1), .out_pc8(pc1), .bubble_cnt(bc1), .stall_cnt(sc1)
    );

    always #5 clk = ~clk;

    // Behavioural model: one entry per instance.
    logic         mv  [2];
    logic [W-1:0] md  [2];
    logic [31:0]  mir [2];
    logic [31:0]  mpc [2];
    int           mb  [2];
    int           ms  [2];
    bit           keep [2] = '{1'b0, 1'b1};
    int           cmax [2] = '{65535, 15};

    initial begin
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; md[i] = '0; mir[i] = '0;
            mpc[i] = '0; mb[i] = 0; ms[i] = 0;
        end
    end

    // Model update on each edge, reset taking effect immediately.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mv[i] <= 0; md[i] <= '0; mir[i] <= '0;
                mpc[i] <= '0; mb[i] <= 0; ms[i] <= 0;
            end else if (flush) begin
                mv[i]  <= 0;
                md[i]  <= '0;
                mir[i] <= '0;
                if (!keep[i]) mpc[i] <= '0;
                mb[i] <= (mb[i] < cmax[i]) ? mb[i] + 1 : mb[i];
            end else if (stall) begin
                ms[i] <= (ms[i] < cmax[i]) ? ms[i] + 1 : ms[i];
            end else begin
                mv[i]  <= in_valid;
                md[i]  <= in_valid ? in_data : '0;
                mir[i] <= in_valid ? in_ir : 32'h0;
                mpc[i] <= in_pc4 + 32'd4;
                if (!in_valid)
                    mb[i] <= (mb[i] < cmax[i]) ? mb[i] + 1 : mb[i];
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every-cycle compare of both instances against the model.
    always @(negedge clk) begin
        chk("m0.valid", 128'(v0),  128'(mv[0]));
        chk("m0.data",  128'(d0),  128'(md[0]));
        chk("m0.ir",    128'(ir0), 128'(mir[0]));
        chk("m0.pc8",   128'(pc0), 128'(mpc[0]));
        chk("m0.bcnt",  128'(bc0), 128'(mb[0]));
        chk("m0.scnt",  128'(sc0), 128'(ms[0]));
        chk("m1.valid", 128'(v1),  128'(mv[1]));
        chk("m1.data",  128'(d1),  128'(md[1]));
        chk("m1.ir",    128'(ir1), 128'(mir[1]));
        chk("m1.pc8",   128'(pc1), 128'(mpc[1]));
        chk("m1.bcnt",  128'(bc1), 128'(mb[1]));
        chk("m1.scnt",  128'(sc1), 128'(ms[1]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic v,
                       input logic [31:0] ir, input logic [31:0] p0,
                       input logic [31:0] p1, input logic [31:0] c0);
        chk({nm, ".v0"},   128'(v0),         128'(v));
        chk({nm, ".v1"},   128'(v1),         128'(v));
        chk({nm, ".ir0"},  128'(ir0),        128'(ir));
        chk({nm, ".ir1"},  128'(ir1),        128'(ir));
        chk({nm, ".pc0"},  128'(pc0),        128'(p0));
        chk({nm, ".pc1"},  128'(pc1),        128'(p1));
        chk({nm, ".ch0_0"}, 128'(d0[31:0]),  128'(c0));
        chk({nm, ".ch0_1"}, 128'(d1[31:0]),  128'(c0));
    endtask

    task automatic cnt(input string nm, input int b0, input int s0,
                       input int b1, input int s1);
        chk({nm, ".b0"}, 128'(bc0), 128'(b0));
        chk({nm, ".s0"}, 128'(sc0), 128'(s0));
        chk({nm, ".b1"}, 128'(bc1), 128'(b1));
        chk({nm, ".s1"}, 128'(sc1), 128'(s1));
    endtask

    task automatic load35();
        in_valid = 1; in_ir = 32'h8C220004; in_pc4 = 32'h00003004;
        in_data  = {32'h33, 32'h22, 32'h11};
    endtask

    logic [W-1:0] pats [3] = '{
        {32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF},
        {32'h00000001, 32'h80000000, 32'h00000000},
        {32'h00000000, 32'hFFFFFFFF, 32'h5A5A5A5A}
    };

    initial begin
        reset = 1'b1;
        #1;
        lit("rst_async", 0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(); step();
        lit("rst", 0, 32'h0, 32'h0, 32'h0, 32'h0);
        cnt("rst", 0, 0, 0, 0);
        @(negedge clk); reset = 1'b0;

        load35();
        step();
        lit("load", 1, 32'h8C220004, 32'h3008, 32'h3008, 32'h11);
        chk("load.data", 128'(d0), 128'({32'h33, 32'h22, 32'h11}));

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_ir = 32'h1000 + 32'(i); in_pc4 = 32'h7000;
            in_data = '1; in_valid = 1;
            step();
            lit("stall", 1, 32'h8C220004, 32'h3008, 32'h3008, 32'h11);
        end
        cnt("stall3", 0, 3, 0, 3);

        flush = 1; stall = 1;
        step();
        lit("flush", 0, 32'h0, 32'h0, 32'h3008, 32'h0);
        chk("flush.data", 128'(d1), 128'(0));
        cnt("flush", 1, 3, 1, 3);

        flush = 0; stall = 0;
        in_valid = 0; in_pc4 = 32'h100; in_ir = 32'hFFFF; in_data = '1;
        step();
        lit("bub", 0, 32'h0, 32'h104, 32'h104, 32'h0);
        cnt("bub", 2, 3, 2, 3);

        stall = 1;
        step();
        lit("bubhold", 0, 32'h0, 32'h104, 32'h104, 32'h0);
        cnt("bubhold", 2, 4, 2, 4);

        stall = 0;
        in_valid = 1; in_pc4 = 32'hFFFFFFFC; in_ir = 32'h13; in_data = '0;
        step();
        lit("wrap", 1, 32'h13, 32'h0, 32'h0, 32'h0);

        for (int i = 0; i < 3; i++) begin
            in_data = pats[i]; in_ir = 32'h00500013 + 32'(i);
            in_pc4 = 32'h2000 + 32'(4 * i);
            step();
            chk("chan.d0", 128'(d0), 128'(pats[i]));
            chk("chan.d1", 128'(d1), 128'(pats[i]));
        end

        stall = 1;
        for (int i = 0; i < 20; i++) step();
        cnt("sat", 2, 24, 2, 15);

        stall = 0;
        load35();
        in_ir = 32'h00A00093;
        step();
        lit("preRst", 1, 32'h00A00093, 32'h3008, 32'h3008, 32'h11);
        #2;
        reset = 1;
        #1;
        lit("rstMid", 0, 32'h0, 32'h0, 32'h0, 32'h0);
        cnt("rstMid", 0, 0, 0, 0);
        flush = 1; stall = 1; in_valid = 1; in_ir = 32'hDEAD;
        step();
        lit("rstHold", 0, 32'h0, 32'h0, 32'h0, 32'h0);
        cnt("rstHold", 0, 0, 0, 0);
        @(negedge clk);
        reset = 0; flush = 0; stall = 0;
        load35();
        step();
        lit("postRst", 1, 32'h8C220004, 32'h3008, 32'h3008, 32'h11);
        cnt("postRst", 0, 0, 0, 0);

        in_valid = 0;
        step();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
